vec_mul_sched: RTL and testbench
================================

# vec_mul_sched

Sequencer for the 1x64 vector-multiply datapath. On a `start` pulse it pops one weight set from the weight FIFO and pulses `weight_reload` into the array. It then streams `vec_count` input vectors out of the unified-buffer SRAM at consecutive addresses. Each array output is written into the results SRAM at consecutive addresses once its pipeline latency has elapsed. It replaces the hand-driven `fifo_read_enable`, `weight_reload` and shared `sram_address` pins at the top level.

## Interface
Parameters:
- `ADDRESSSIZE`, 10: width of all SRAM addresses.
- `COUNT_BW`, 10: width of `vec_count`.
- `PIPE_LAT`, 10: cycles from `ub_rd_en`/`ub_addr` issue to the matching array result being valid at `data_out`. Includes the 1-cycle SRAM read. Legal range is 1..31.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rstn` in 1: reset, asynchronous assert, active-low.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `src_base` in ADDRESSSIZE: first unified-buffer address; captured on accepted `start`.
- `dst_base` in ADDRESSSIZE: first results-SRAM address; captured on accepted `start`.
- `vec_count` in COUNT_BW: number of vectors; captured on accepted `start`.
- `fifo_empty` in 1: weight FIFO empty flag.
- `fifo_read_enable` out 1: one-cycle weight FIFO pop.
- `weight_reload` out 1: one-cycle array weight-latch strobe.
- `ub_rd_en` out 1: unified-buffer read qualifier.
- `ub_addr` out ADDRESSSIZE: unified-buffer read address.
- `res_we` out 1: results-SRAM write enable.
- `res_addr` out ADDRESSSIZE: results-SRAM write address.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, LOAD_W, RELOAD, STREAM, DRAIN, DONE.
- IDLE:
  - `start`=1 with `vec_count`≠0: capture the inputs and go to LOAD_W.
  - `start`=1 with `vec_count`=0: go directly to DONE. No FIFO pop, no reload.
- LOAD_W:
  - While `fifo_empty`=1, hold. `fifo_read_enable` stays 0.
  - When `fifo_empty`=0, assert `fifo_read_enable` for exactly one cycle and go to RELOAD.
- RELOAD: assert `weight_reload` for exactly one cycle, then go to STREAM.
- STREAM:
  - Each cycle: `ub_rd_en`=1 and `ub_addr`=`src_base`+i, for i = 0..`vec_count`-1.
  - After the last issue, go to DRAIN.
- DRAIN: stay until the valid delay line is empty, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Valid delay line:
  - `PIPE_LAT`-deep shift register fed by `ub_rd_en`. Its tail drives `res_we`.
  - A `res_addr` counter starts at `dst_base` and increments after each `res_we` cycle.
- Address arithmetic: `src_base`+i and `res_addr` increments are modulo 2^ADDRESSSIZE and wrap silently.
- `start` while `busy`=1 is ignored. It has no effect on captured values or state.
- Reset mid-operation: all state and outputs clear immediately. In-flight results are discarded, with no `res_we`. A FIFO entry already popped is not restored.

## Timing
- Reset values: state IDLE; every output 0. `ub_addr` and `res_addr` are 0.
- All outputs are registered. No combinational path exists from any input to any output.
- Normal sequence, with `start` in cycle 0 and FIFO non-empty:
  - `fifo_read_enable` high in cycle 1.
  - `weight_reload` high in cycle 2.
  - `ub_rd_en` high in cycles 3..3+N-1.
  - `res_we` high in cycles 3+PIPE_LAT..3+PIPE_LAT+N-1.
  - `done` high in cycle 3+PIPE_LAT+N.
- Each cycle of `fifo_empty`=1 in LOAD_W delays everything after it by one cycle.
- `vec_count`=0: `done` high in cycle 1.
- Throughput is one vector per cycle. There are no bubbles within STREAM.
- `busy` rises in the cycle after an accepted `start` and falls together with `done`.

## Structure
- Package `vec_mul_sched_pkg` holds:
  - the FSM state enum, 3-bit encoded;
  - the default `PIPE_LAT` constant, shared with the top level.
- Sub-module `vec_mul_valid_pipe`: parameterised 1-bit shift register of depth `PIPE_LAT`, reset to all zeros. It exposes its tail bit and an any-bit-set flag, which DRAIN uses for exit.
- FSM and address counters live in the parent module.

## Test plan
- Basic run:
  - Stimulus: `src_base`=0x010, `dst_base`=0x100, `vec_count`=4, FIFO non-empty, `PIPE_LAT`=10.
  - Response: `ub_addr` 0x010..0x013 in cycles 3..6; `res_we` in cycles 13..16 with `res_addr` 0x100..0x103; `done` in cycle 17.
- Empty FIFO stall:
  - Stimulus: `fifo_empty`=1 for 5 cycles after `start`.
  - Response: `fifo_read_enable` first high in cycle 6; all later events shift by +5.
- Zero count:
  - Stimulus: `vec_count`=0.
  - Response: `done` in cycle 1; `fifo_read_enable`, `weight_reload`, `ub_rd_en` and `res_we` never assert.
- Wrap-around:
  - Stimulus: `src_base`=1020, `dst_base`=1022, `vec_count`=8.
  - Response: `ub_addr` sequence 1020..1023, 0..3; `res_addr` sequence 1022, 1023, 0..5.
- Reset mid-stream:
  - Stimulus: `rstn` low during the third STREAM cycle.
  - Response: all outputs 0 in the same cycle; after release, no `res_we` and no `done` until a new `start`.
- Start while busy:
  - Stimulus: second `start` with different bases during STREAM.
  - Response: it is ignored; addresses and `done` timing match the first request exactly.

Source files
------------

// File: rtl/vec_mul_sched_pkg.sv
// Shared types and defaults for the 1x64 vector-multiply sequencer.
package vec_mul_sched_pkg;

    localparam int DEFAULT_PIPE_LAT = 10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        RELOAD = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_e;

endpackage

// File: rtl/vec_mul_valid_pipe.sv
// Valid delay line matching the array latency; its tail marks a result ready to store.
module vec_mul_valid_pipe #(
    parameter int DEPTH = 10
) (
    input  logic clk,
    input  logic rstn,
    input  logic valid_in,
    output logic tail,
    output logic any_set
);

    logic [DEPTH-1:0] stage;

    assign tail = stage[DEPTH-1];

    // any_set looks one shift ahead: it is clear exactly when the line will be empty next cycle.
    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    stage <= '0;
                end else begin
                    stage[0] <= valid_in;
                end
            end
            assign any_set = valid_in;
        end else begin : g_multi
            // NOTE: state registers use non-blocking assignments so every stage shifts on the same edge.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    stage <= '0;
                end else begin
                    stage <= {stage[DEPTH-2:0], valid_in};
                end
            end
            assign any_set = valid_in | (|stage[DEPTH-2:0]);
        end
    endgenerate

endmodule

// File: rtl/vec_mul_sched.sv
// Sequencer: pops one weight set, reloads the array, streams vectors and stores results.
module vec_mul_sched
    import vec_mul_sched_pkg::*;
#(
    parameter int ADDRESSSIZE = 10,
    parameter int COUNT_BW    = 10,
    parameter int PIPE_LAT    = DEFAULT_PIPE_LAT
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [ADDRESSSIZE-1:0] src_base,
    input  logic [ADDRESSSIZE-1:0] dst_base,
    input  logic [COUNT_BW-1:0]    vec_count,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    output logic                   weight_reload,
    output logic                   ub_rd_en,
    output logic [ADDRESSSIZE-1:0] ub_addr,
    output logic                   res_we,
    output logic [ADDRESSSIZE-1:0] res_addr,
    output logic                   busy,
    output logic                   done
);

    state_e                 state;
    logic [ADDRESSSIZE-1:0] src_q;
    logic [COUNT_BW-1:0]    count_q;
    logic [COUNT_BW-1:0]    remaining;
    logic                   pipe_any;

    vec_mul_valid_pipe #(
        .DEPTH (PIPE_LAT)
    ) u_valid_pipe (
        .clk      (clk),
        .rstn     (rstn),
        .valid_in (ub_rd_en),
        .tail     (res_we),
        .any_set  (pipe_any)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= IDLE;
            src_q            <= '0;
            count_q          <= '0;
            remaining        <= '0;
            fifo_read_enable <= 1'b0;
            weight_reload    <= 1'b0;
            ub_rd_en         <= 1'b0;
            ub_addr          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q   <= src_base;
                        count_q <= vec_count;
                        busy    <= 1'b1;
                        if (vec_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            // The FIFO flag is already examined in the start cycle, so the pop lands in cycle 1.
                            state            <= LOAD_W;
                            fifo_read_enable <= !fifo_empty;
                        end
                    end
                end
                LOAD_W: begin
                    if (fifo_read_enable) begin
                        fifo_read_enable <= 1'b0;
                        weight_reload    <= 1'b1;
                        state            <= RELOAD;
                    end else if (!fifo_empty) begin
                        fifo_read_enable <= 1'b1;
                    end
                end
                RELOAD: begin
                    weight_reload <= 1'b0;
                    ub_rd_en      <= 1'b1;
                    ub_addr       <= src_q;
                    remaining     <= count_q - COUNT_BW'(1);
                    state         <= STREAM;
                end
                STREAM: begin
                    if (remaining == '0) begin
                        ub_rd_en <= 1'b0;
                        state    <= DRAIN;
                    end else begin
                        ub_addr   <= ub_addr + ADDRESSSIZE'(1);
                        remaining <= remaining - COUNT_BW'(1);
                    end
                end
                DRAIN: begin
                    if (!pipe_any) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result address advances after every stored result and wraps silently.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_addr <= '0;
        end else if (state == IDLE && start) begin
            res_addr <= dst_base;
        end else if (res_we) begin
            res_addr <= res_addr + ADDRESSSIZE'(1);
        end
    end

endmodule

// File: tb/tb_vec_mul_sched.sv
// Self-checking bench for vec_mul_sched against a cycle-schedule reference model.
module tb_vec_mul_sched;

    localparam int AW = 10;
    localparam int CW = 10;
    localparam int L  = 10;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [AW-1:0] src_base;
    logic [AW-1:0] dst_base;
    logic [CW-1:0] vec_count;
    logic          fifo_empty;
    logic          fifo_read_enable;
    logic          weight_reload;
    logic          ub_rd_en;
    logic [AW-1:0] ub_addr;
    logic          res_we;
    logic [AW-1:0] res_addr;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    vec_mul_sched #(
        .ADDRESSSIZE (AW),
        .COUNT_BW    (CW),
        .PIPE_LAT    (L)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .start            (start),
        .src_base         (src_base),
        .dst_base         (dst_base),
        .vec_count        (vec_count),
        .fifo_empty       (fifo_empty),
        .fifo_read_enable (fifo_read_enable),
        .weight_reload    (weight_reload),
        .ub_rd_en         (ub_rd_en),
        .ub_addr          (ub_addr),
        .res_we           (res_we),
        .res_addr         (res_addr),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    // Cycle 0 is the cycle in which start is high; inputs change 1 ns after a rising edge
    // and outputs are sampled on the falling edge.
    task automatic run_job(input int src, input int dst, input int n, input int stall,
                           input int dup_at, input string tag);
        int  done_c;
        int  last_c;
        bit  fre_e, wr_e, en_e, we_e, done_e, busy_e;
        int  ua_e, ra_e;
        done_c = (n == 0) ? 1 : 3 + stall + L + n;
        last_c = done_c + 2;
        for (int c = 0; c <= last_c; c++) begin
            start = (c == 0) || (c == dup_at);
            if (c == 0) begin
                src_base  = AW'(src);
                dst_base  = AW'(dst);
                vec_count = CW'(n);
            end else if (c == dup_at) begin
                src_base  = AW'($urandom);
                dst_base  = AW'($urandom);
                vec_count = CW'($urandom_range(1, 40));
            end
            if (c < stall)       fifo_empty = 1'b1;
            else if (c == stall) fifo_empty = 1'b0;
            else                 fifo_empty = 1'($urandom_range(0, 1));
            @(negedge clk);
            fre_e  = (n != 0) && (c == 1 + stall);
            wr_e   = (n != 0) && (c == 2 + stall);
            en_e   = (n != 0) && (c >= 3 + stall) && (c < 3 + stall + n);
            we_e   = (n != 0) && (c >= 3 + stall + L) && (c < 3 + stall + L + n);
            done_e = (c == done_c);
            busy_e = (c >= 1) && (c <= done_c);
            ua_e   = (src + (c - 3 - stall)) % (1 << AW);
            ra_e   = (dst + (c - 3 - stall - L)) % (1 << AW);
            checks++;
            if (fifo_read_enable !== fre_e) begin
                errors++;
                $display("FAIL %s fifo_read_enable cycle %0d: got %b expected %b", tag, c, fifo_read_enable, fre_e);
            end
            checks++;
            if (weight_reload !== wr_e) begin
                errors++;
                $display("FAIL %s weight_reload cycle %0d: got %b expected %b", tag, c, weight_reload, wr_e);
            end
            checks++;
            if (ub_rd_en !== en_e) begin
                errors++;
                $display("FAIL %s ub_rd_en cycle %0d: got %b expected %b", tag, c, ub_rd_en, en_e);
            end
            if (en_e) begin
                checks++;
                if (ub_addr !== AW'(ua_e)) begin
                    errors++;
                    $display("FAIL %s ub_addr cycle %0d: got %0d expected %0d", tag, c, ub_addr, ua_e);
                end
            end
            checks++;
            if (res_we !== we_e) begin
                errors++;
                $display("FAIL %s res_we cycle %0d: got %b expected %b", tag, c, res_we, we_e);
            end
            if (we_e) begin
                checks++;
                if (res_addr !== AW'(ra_e)) begin
                    errors++;
                    $display("FAIL %s res_addr cycle %0d: got %0d expected %0d", tag, c, res_addr, ra_e);
                end
            end
            checks++;
            if (done !== done_e) begin
                errors++;
                $display("FAIL %s done cycle %0d: got %b expected %b", tag, c, done, done_e);
            end
            checks++;
            if (busy !== busy_e) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b expected %b", tag, c, busy, busy_e);
            end
            @(posedge clk);
            #1;
        end
        start      = 1'b0;
        fifo_empty = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({fifo_read_enable, weight_reload, ub_rd_en, res_we, busy, done} !== 6'b0) begin
            errors++;
            $display("FAIL %s strobes: got %b expected 000000", tag,
                     {fifo_read_enable, weight_reload, ub_rd_en, res_we, busy, done});
        end
        checks++;
        if (ub_addr !== '0 || res_addr !== '0) begin
            errors++;
            $display("FAIL %s addresses: got ub_addr=%0d res_addr=%0d expected 0 0", tag, ub_addr, res_addr);
        end
    endtask

    task automatic test_reset();
        rstn       = 1'b0;
        start      = 1'b0;
        src_base   = '0;
        dst_base   = '0;
        vec_count  = '0;
        fifo_empty = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        run_job(16, 256, 4, 0, -1, "basic");
    endtask

    task automatic test_fifo_stall();
        run_job(100, 300, 3, 5, -1, "stall");
    endtask

    task automatic test_zero_count();
        run_job(5, 7, 0, 0, -1, "zero");
    endtask

    task automatic test_wrap();
        run_job(1020, 1022, 8, 0, -1, "wrap");
    endtask

    task automatic test_start_while_busy();
        run_job(40, 500, 6, 0, 5, "dup_start");
    endtask

    task automatic test_reset_mid_stream();
        start      = 1'b1;
        src_base   = AW'(200);
        dst_base   = AW'(600);
        vec_count  = CW'(8);
        fifo_empty = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        // Now in cycle 5, the third STREAM cycle.
        checks++;
        if (ub_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid ub_rd_en before reset: got %b expected 1", ub_rd_en);
        end
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int c = 0; c < 3 * L; c++) begin
            @(negedge clk);
            checks++;
            if (res_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid quiet cycle %0d: got res_we=%b done=%b busy=%b expected 0 0 0",
                         c, res_we, done, busy);
            end
            @(posedge clk);
            #1;
        end
        run_job(3, 9, 2, 1, -1, "after_rst");
    endtask

    task automatic test_random();
        int n, stall, dup;
        for (int k = 0; k < 8; k++) begin
            n     = int'($urandom_range(1, 24));
            stall = int'($urandom_range(0, 4));
            dup   = (n >= 2 && $urandom_range(0, 1) == 1)
                    ? 3 + stall + int'($urandom_range(0, n - 1)) : -1;
            run_job(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), n, stall, dup, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fifo_stall();
        test_zero_count();
        test_wrap();
        test_start_while_busy();
        test_reset_mid_stream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
